// File: rtl/snp_req_initiator.sv
// Snoop-channel initiator: broadcasts one coherence request to every peer except the
// requester, collects the per-peer responses and reports a single hit/owner/error summary.
module snp_req_initiator #(
    parameter int NUM_PEER = 4,
    parameter int ADDR_W   = 32,
    parameter int TIMEOUT  = 255,
    parameter int SRC_W    = (NUM_PEER > 1) ? $clog2(NUM_PEER) : 1,
    // Opcode/response encodings shared with the cache snoop handlers
    parameter logic [1:0] SUREQ_INV  = 2'd2,
    parameter logic [1:0] SDRSP_OKAY = 2'd0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [SRC_W-1:0]      req_src,
    output logic [NUM_PEER-1:0]   su_req_valid,
    input  logic [NUM_PEER-1:0]   su_req_ready,
    output logic [1:0]            su_req_op,
    output logic [ADDR_W-1:0]     su_req_addr,
    input  logic [NUM_PEER-1:0]   sd_rsp_valid,
    input  logic [2*NUM_PEER-1:0] sd_rsp,
    output logic                  done_valid,
    input  logic                  done_ready,
    output logic                  done_hit,
    output logic [SRC_W-1:0]      done_owner,
    output logic                  done_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t                state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [NUM_PEER-1:0]   send_q, send_d;
    logic [NUM_PEER-1:0]   rsp_q, rsp_d;
    logic [NUM_PEER-1:0]   hit_q, hit_d;
    logic                  err_q, err_d;
    logic [15:0]           tcnt_q, tcnt_d;
    logic                  req_ready_q, req_ready_d;
    logic                  done_valid_q, done_valid_d;
    logic                  done_hit_q, done_hit_d;
    logic [SRC_W-1:0]      done_owner_q, done_owner_d;
    logic                  done_err_q, done_err_d;

    logic [NUM_PEER-1:0]   init_mask;
    logic                  tmo_hit;
    logic                  finish;

    function automatic logic [SRC_W-1:0] lowest_set(input logic [NUM_PEER-1:0] m);
        lowest_set = '0;
        for (int i = NUM_PEER - 1; i >= 0; i--) begin
            if (m[i]) lowest_set = SRC_W'(i);
        end
    endfunction

    // An out-of-range requester index leaves every peer in the broadcast set
    always_comb begin
        init_mask = '1;
        for (int i = 0; i < NUM_PEER; i++) begin
            if (int'(req_src) == i) init_mask[i] = 1'b0;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        addr_d       = addr_q;
        send_d       = send_q;
        rsp_d        = rsp_q;
        hit_d        = hit_q;
        err_d        = err_q;
        tcnt_d       = tcnt_q;
        req_ready_d  = req_ready_q;
        done_valid_d = done_valid_q;
        done_hit_d   = done_hit_q;
        done_owner_d = done_owner_q;
        done_err_d   = done_err_q;
        tmo_hit      = 1'b0;
        finish       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d        = req_op;
                    addr_d      = req_addr;
                    send_d      = init_mask;
                    rsp_d       = init_mask;
                    hit_d       = '0;
                    err_d       = 1'b0;
                    tcnt_d      = '0;
                    req_ready_d = 1'b0;
                    if (init_mask == '0) begin
                        state_d      = DONE;
                        done_valid_d = 1'b1;
                        done_hit_d   = 1'b0;
                        done_owner_d = '0;
                        done_err_d   = 1'b0;
                    end else begin
                        state_d = SEND;
                    end
                end
            end

            SEND, WAIT: begin
                send_d = send_q & ~su_req_ready;
                // A response is legal only after that peer's request has already handshaked
                for (int i = 0; i < NUM_PEER; i++) begin
                    if (sd_rsp_valid[i]) begin
                        if (rsp_q[i] && !send_q[i]) begin
                            rsp_d[i] = 1'b0;
                            if (sd_rsp[2*i +: 2] == SDRSP_OKAY && op_q != SUREQ_INV)
                                hit_d[i] = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                if (tcnt_q != 16'hFFFF) tcnt_d = tcnt_q + 16'd1;
                tmo_hit = (TIMEOUT != 0) && (tcnt_q == TMO_LAST);
                if (tmo_hit) begin
                    err_d  = 1'b1;
                    send_d = '0;
                    rsp_d  = '0;
                    finish = 1'b1;
                end else if (rsp_d == '0) begin
                    finish = 1'b1;
                end else if (send_d == '0) begin
                    state_d = WAIT;
                end
                if (finish) begin
                    state_d      = DONE;
                    done_valid_d = 1'b1;
                    done_hit_d   = |hit_d;
                    done_owner_d = lowest_set(hit_d);
                    done_err_d   = err_d;
                end
            end

            DONE: begin
                if (done_ready) begin
                    state_d      = IDLE;
                    req_ready_d  = 1'b1;
                    done_valid_d = 1'b0;
                    done_hit_d   = 1'b0;
                    done_owner_d = '0;
                    done_err_d   = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            op_q         <= '0;
            addr_q       <= '0;
            send_q       <= '0;
            rsp_q        <= '0;
            hit_q        <= '0;
            err_q        <= 1'b0;
            tcnt_q       <= '0;
            req_ready_q  <= 1'b1;
            done_valid_q <= 1'b0;
            done_hit_q   <= 1'b0;
            done_owner_q <= '0;
            done_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            send_q       <= send_d;
            rsp_q        <= rsp_d;
            hit_q        <= hit_d;
            err_q        <= err_d;
            tcnt_q       <= tcnt_d;
            req_ready_q  <= req_ready_d;
            done_valid_q <= done_valid_d;
            done_hit_q   <= done_hit_d;
            done_owner_q <= done_owner_d;
            done_err_q   <= done_err_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign su_req_valid = send_q;
    assign su_req_op    = op_q;
    assign su_req_addr  = addr_q;
    assign done_valid   = done_valid_q;
    assign done_hit     = done_hit_q;
    assign done_owner   = done_owner_q;
    assign done_err     = done_err_q;

endmodule

// File: tb/tb_snp_req_initiator.sv
// Bench for snp_req_initiator: table of transactions driven through a cycle-accurate peer model,
// expected summaries queued at accept and compared when done_valid appears.
module tb_snp_req_initiator;

    localparam logic [1:0] RD  = 2'd0;
    localparam logic [1:0] RFO = 2'd1;
    localparam logic [1:0] INV = 2'd2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_addr;
    logic [1:0]  req_src;
    logic [3:0]  su_req_valid;
    logic [3:0]  su_req_ready;
    logic [1:0]  su_req_op;
    logic [31:0] su_req_addr;
    logic [3:0]  sd_rsp_valid;
    logic [7:0]  sd_rsp;
    logic        done_valid;
    logic        done_ready;
    logic        done_hit;
    logic [1:0]  done_owner;
    logic        done_err;

    snp_req_initiator #(
        .NUM_PEER(4),
        .ADDR_W  (32),
        .TIMEOUT (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_addr    (req_addr),
        .req_src     (req_src),
        .su_req_valid(su_req_valid),
        .su_req_ready(su_req_ready),
        .su_req_op   (su_req_op),
        .su_req_addr (su_req_addr),
        .sd_rsp_valid(sd_rsp_valid),
        .sd_rsp      (sd_rsp),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .done_hit    (done_hit),
        .done_owner  (done_owner),
        .done_err    (done_err)
    );

    always #5 clk = ~clk;

    // rdy: per-peer ready cycle (nibble i = peer i); rsp: per-peer response (2 bits each)
    typedef struct {
        logic [1:0]  op;
        logic [1:0]  src;
        logic [31:0] addr;
        logic [15:0] rdy;
        logic [7:0]  rsp;
        logic [3:0]  en;
        logic [3:0]  bad;
        logic [3:0]  late;
        logic [3:0]  mask;
        logic        hit;
        logic [1:0]  owner;
        logic        err;
        int          done_c;
        int          hold;
    } vec_t;

    typedef struct {
        logic       hit;
        logic [1:0] owner;
        logic       err;
        int         done_c;
    } exp_t;

    vec_t vecs[8];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic [1:0] src, input logic [31:0] addr,
                                input logic [15:0] rdy, input logic [7:0] rsp, input logic [3:0] en,
                                input logic [3:0] bad, input logic [3:0] late, input logic [3:0] mask,
                                input logic hit, input logic [1:0] owner, input logic err,
                                input int done_c, input int hold);
        vec_t v;
        v.op = op; v.src = src; v.addr = addr; v.rdy = rdy; v.rsp = rsp; v.en = en;
        v.bad = bad; v.late = late; v.mask = mask; v.hit = hit; v.owner = owner;
        v.err = err; v.done_c = done_c; v.hold = hold;
        return v;
    endfunction

    task automatic idle_inputs();
        req_valid    = 1'b0;
        req_op       = 2'd0;
        req_addr     = 32'd0;
        req_src      = 2'd0;
        su_req_ready = 4'd0;
        sd_rsp_valid = 4'd0;
        sd_rsp       = 8'd0;
        done_ready   = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   hs[4];
        int   c;
        int   held;
        bit   seen;
        bit   fin;
        exp_t e;
        for (int i = 0; i < 4; i++) hs[i] = -1;
        seen = 1'b0;
        fin  = 1'b0;
        held = 0;
        e    = '{1'b0, 2'd0, 1'b0, 0};
        chk($sformatf("v%0d_req_ready_idle", idx), 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_op    = v.op;
        req_addr  = v.addr;
        req_src   = v.src;
        sb.push_back('{v.hit, v.owner, v.err, v.done_c});
        @(posedge clk); #1;
        idle_inputs();
        c = 1;
        while (c < 40 && !fin) begin
            su_req_ready = 4'd0;
            sd_rsp_valid = 4'd0;
            sd_rsp       = 8'd0;
            done_ready   = 1'b0;
            if (c == 1) begin
                chk($sformatf("v%0d_su_req_valid", idx), 64'(su_req_valid), 64'(v.mask));
                chk($sformatf("v%0d_su_req_op", idx), 64'(su_req_op), 64'(v.op));
                chk($sformatf("v%0d_su_req_addr", idx), 64'(su_req_addr), 64'(v.addr));
            end
            for (int i = 0; i < 4; i++) begin
                if (c >= int'(v.rdy[4*i +: 4])) su_req_ready[i] = 1'b1;
                if (su_req_valid[i] && su_req_ready[i] && hs[i] < 0) hs[i] = c;
                if (v.en[i] && hs[i] >= 0 && c == hs[i] + 1) begin
                    sd_rsp_valid[i]  = 1'b1;
                    sd_rsp[2*i +: 2] = v.rsp[2*i +: 2];
                end
                if (v.bad[i] && c == 2) sd_rsp_valid[i] = 1'b1;
            end
            if (done_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    e = sb.pop_front();
                    chk($sformatf("v%0d_done_cycle", idx), 64'(c), 64'(e.done_c));
                end
                chk($sformatf("v%0d_done_hit", idx), 64'(done_hit), 64'(e.hit));
                chk($sformatf("v%0d_done_owner", idx), 64'(done_owner), 64'(e.owner));
                chk($sformatf("v%0d_done_err", idx), 64'(done_err), 64'(e.err));
                if (held < v.hold) begin
                    held++;
                end else begin
                    done_ready = 1'b1;
                    chk($sformatf("v%0d_req_ready_in_hs", idx), 64'(req_ready), 64'd0);
                    fin = 1'b1;
                end
            end
            @(posedge clk); #1;
            c++;
        end
        idle_inputs();
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL v%0d_no_done actual=none expected=done_valid by cycle %0d", idx, v.done_c);
            void'(sb.pop_front());
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
        end else begin
            sd_rsp_valid = v.late;
            chk($sformatf("v%0d_req_ready_after", idx), 64'(req_ready), 64'd1);
            chk($sformatf("v%0d_done_valid_after", idx), 64'(done_valid), 64'd0);
            @(posedge clk); #1;
            sd_rsp_valid = 4'd0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        chk({tag, "_su_req_valid"}, 64'(su_req_valid), 64'd0);
        chk({tag, "_su_req_op"}, 64'(su_req_op), 64'd0);
        chk({tag, "_su_req_addr"}, 64'(su_req_addr), 64'd0);
        chk({tag, "_done_valid"}, 64'(done_valid), 64'd0);
        chk({tag, "_done_hit"}, 64'(done_hit), 64'd0);
        chk({tag, "_done_owner"}, 64'(done_owner), 64'd0);
        chk({tag, "_done_err"}, 64'(done_err), 64'd0);
    endtask

    initial begin
        //            op   src   addr          rdy       rsp           en       bad      late     mask     hit   own   err  done hold
        vecs[0] = mk(RD,  2'd0, 32'h0000_0040, 16'h1111, 8'b01_00_01_00, 4'b1110, 4'b0000, 4'b0000, 4'b1110, 1'b1, 2'd2, 1'b0, 3, 0);
        vecs[1] = mk(RFO, 2'd3, 32'h0000_1000, 16'h1111, 8'b00_01_00_00, 4'b0111, 4'b0000, 4'b0000, 4'b0111, 1'b1, 2'd0, 1'b0, 3, 2);
        vecs[2] = mk(INV, 2'd1, 32'h0000_2040, 16'h1111, 8'b00_00_00_00, 4'b1101, 4'b0000, 4'b0000, 4'b1101, 1'b0, 2'd0, 1'b0, 3, 0);
        vecs[3] = mk(RD,  2'd3, 32'h0000_0080, 16'h1115, 8'b00_00_00_01, 4'b0111, 4'b0000, 4'b0000, 4'b0111, 1'b1, 2'd1, 1'b0, 7, 0);
        vecs[4] = mk(RD,  2'd0, 32'h0000_00C0, 16'h1111, 8'b00_01_00_00, 4'b0110, 4'b0000, 4'b1000, 4'b1110, 1'b1, 2'd1, 1'b1, 9, 0);
        vecs[5] = mk(RFO, 2'd2, 32'h0000_0100, 16'h2113, 8'b00_00_01_01, 4'b1011, 4'b0000, 4'b0000, 4'b1011, 1'b1, 2'd3, 1'b0, 5, 0);
        vecs[6] = mk(RD,  2'd0, 32'h0000_0140, 16'h1111, 8'b00_00_00_00, 4'b1110, 4'b0001, 4'b0000, 4'b1110, 1'b1, 2'd1, 1'b1, 3, 0);
        vecs[7] = mk(RFO, 2'd0, 32'hDEAD_BEC0, 16'h1111, 8'b01_01_01_01, 4'b1110, 4'b0000, 4'b0000, 4'b1110, 1'b0, 2'd0, 1'b0, 3, 0);

        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        for (int k = 0; k < 8; k++) run_vec(vecs[k], k);

        // Reset while waiting for responses, then a stale response must be ignored
        req_valid = 1'b1;
        req_op    = RFO;
        req_addr  = 32'h0000_0200;
        req_src   = 2'd0;
        @(posedge clk); #1;
        idle_inputs();
        su_req_ready = 4'b1111;
        @(posedge clk); #1;
        su_req_ready = 4'd0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_all_zero("midrst");
        sd_rsp_valid = 4'b0010;
        @(posedge clk); #1;
        sd_rsp_valid = 4'd0;
        check_all_zero("midrst_late");
        run_vec(vecs[0], 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/snp_req_initiator.md
Name: snp_req_initiator

Overview:
Initiator side of the snoop channel. Takes one coherence request from the local directory or miss path and broadcasts the matching SUREQ_* op to every peer cache except the requester. It collects each peer's SDRSP_* response and reports one summary: whether any peer supplied the line, which peer did, and whether a timeout occurred. It sits between the miss/upgrade controller and the per-cache snoop request handlers, and handles one transaction at a time.

Parameters:
NUM_PEER, 4, number of peer caches on the snoop channel (1..16)
ADDR_W, 32, line address width
TIMEOUT, 255, max cycles spent in SEND+WAIT before forced completion; 0 disables timeout
SRC_W, $clog2(NUM_PEER) (min 1), width of peer index fields

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  new snoop transaction request
req_ready  out  1  initiator idle, request accepted when valid&ready
req_op  in  2  SUREQ_RD / SUREQ_RFO / SUREQ_INV (encodings from cache_def.sv)
req_addr  in  ADDR_W  line address
req_src  in  SRC_W  requesting cache index, excluded from broadcast
su_req_valid  out  NUM_PEER  per-peer snoop request valid
su_req_ready  in  NUM_PEER  per-peer snoop request ready
su_req_op  out  2  latched op, shared by all peers
su_req_addr  out  ADDR_W  latched address, shared by all peers
sd_rsp_valid  in  NUM_PEER  per-peer response valid, single-cycle pulse
sd_rsp  in  2*NUM_PEER  per-peer response, peer i at [2i+1:2i]; SDRSP_OKAY or SDRSP_INV
done_valid  out  1  summary valid, held until accepted
done_ready  in  1  summary consumer ready
done_hit  out  1  at least one peer answered SDRSP_OKAY for a RD or RFO op
done_owner  out  SRC_W  lowest-index peer answering SDRSP_OKAY; 0 if none
done_err  out  1  timeout, or response from a peer that was not expected

Behaviour:
- Reset: state=IDLE. req_ready=1. su_req_valid=0, su_req_op=0, su_req_addr=0, done_valid=0, done_hit=0, done_owner=0, done_err=0. All masks and the timeout counter are cleared. Reset mid-transaction abandons the transaction, and late peer responses are ignored afterwards.
- FSM states: IDLE, SEND, WAIT, DONE. Internal registers:
  - send_mask[NUM_PEER]: requests not yet handshaked
  - rsp_mask[NUM_PEER]: responses outstanding
  - hit_mask[NUM_PEER]: peers that answered SDRSP_OKAY
  - err flag
  - tcnt, 16-bit, saturating
- IDLE:
  - req_ready=1.
  - On req_valid: latch op, addr and src. Set send_mask=rsp_mask=all ones with bit req_src cleared. If req_src >= NUM_PEER, no bit is cleared. Clear hit_mask, err and tcnt.
  - Go to SEND. If the resulting mask is empty (e.g. NUM_PEER=1), go directly to DONE with hit=0.
- SEND:
  - su_req_valid = send_mask. Bit i clears on su_req_valid[i]&su_req_ready[i].
  - Peers handshake independently and in any order.
  - When send_mask becomes zero (registered next value), go to WAIT.
  - Responses are accepted as in WAIT.
- Response acceptance (SEND and WAIT):
  - sd_rsp_valid[i] is accepted only if rsp_mask[i]=1 and send_mask[i]=0, both as registered values. A response in the same cycle as that peer's request handshake is therefore unexpected.
  - Accepting clears rsp_mask[i]. hit_mask[i] is set if sd_rsp slice == SDRSP_OKAY and op != SUREQ_INV.
  - Any other sd_rsp_valid bit sets err and is otherwise ignored.
  - Multiple peers may respond in the same cycle; all are accepted.
- WAIT: when rsp_mask becomes zero, go to DONE.
- Timeout: tcnt increments each cycle in SEND/WAIT. If TIMEOUT!=0 and tcnt==TIMEOUT-1, go to DONE next cycle with err=1. On timeout, su_req_valid drops and remaining masks clear.
- DONE:
  - done_valid=1. Outputs are registered and stable while done_valid=1 && !done_ready.
  - done_hit = |hit_mask. done_owner = priority-encode lowest set bit of hit_mask. done_err = err.
  - On done_ready, go to IDLE next cycle; req_ready is 0 in that handshake cycle.
- su_req_op/su_req_addr stay at the latched values from acceptance until the next accepted request.
- Latency for a minimum transaction, with all peers ready and responding the cycle after handshake:
  - cycle 0: accept
  - cycle 1: SEND handshake
  - cycle 2: response
  - cycle 3: done_valid

Test Plan:
- NUM_PEER=4, req RD addr=0x40 src=0, all ready, peer2 rsp OKAY, peers 1,3 INV -> su_req_valid=4'b1110 for 1 cycle; done_hit=1, done_owner=2, done_err=0, done_valid at cycle 3.
- RFO src=3, peers 0 and 1 both OKAY in the same cycle -> su_req_valid=4'b0111; done_owner=0, done_hit=1.
- INV src=1, all peers return OKAY -> done_hit=0, done_err=0.
- Staggered readies (peer0 ready at cycle 5, others at 1), responses one cycle after each handshake -> SEND exits only after peer0 handshake; done_valid one cycle after last response.
- TIMEOUT=8, peer3 never responds -> done_valid with done_err=1 at cycle 9 after accept; subsequent late peer3 response ignored, no err on next transaction.
- Response pulse from requester peer, or rst asserted during WAIT -> done_err=1 in first case; in second, next cycle is IDLE, req_ready=1, all outputs zero.
